chunked_serial_adder: RTL and testbench
=======================================

// Module: chunked_serial_adder
// PURPOSE
//   Parametrised multi-cycle adder that replaces the fixed 16-bit ripple adder.
//   Adds two WIDTH-bit operands CHUNK bits per clock, holding the carry in a register between chunks.
//   Long carry chains never sit in one cycle.
//   Used by the sequential multiplier datapath; input and output both use a valid/ready handshake.
// PARAMETERS
//   WIDTH  16  operand/sum width in bits; must be >= 2
//   CHUNK  4   bits added per cycle; WIDTH % CHUNK == 0 (elaboration error otherwise)
//   NCHUNK     localparam = WIDTH/CHUNK; equals cycles per operation
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands and cin valid
//   in_ready   out  1      block can accept (state IDLE)
//   dataa      in   WIDTH  operand A
//   datab      in   WIDTH  operand B
//   cin        in   1      carry-in (add mode)
//   sub        in   1      1 = A - B (only when ADDER_SUB_EN defined)
//   out_valid  out  1      result valid (state DONE)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  registered result
//   cout       out  1      carry out of MSB (subtract: 1 = no borrow)
//   ovf        out  1      two's-complement overflow of the result
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
//   Reset also clears the chunk counter and the internal operand/carry registers.
//   FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1. If in_valid=1 at edge T, load A, B' (B or ~B) and carry (cin or 1).
//     At the same edge: cnt=0, go to RUN.
//   RUN: in_ready=0, out_valid=0.
//     Each cycle, add the low CHUNK bits of A and B' plus the carry register.
//     Place the CHUNK result bits at chunk position cnt of sum; update the carry; shift A and B' right by CHUNK.
//     On cnt==NCHUNK-1: latch cout = final carry and ovf = (A_msb==B'_msb)&&(sum_msb!=A_msb), go to DONE.
//   Latency: out_valid rises right after edge T+NCHUNK. With CHUNK==WIDTH this is 1 cycle.
//   DONE: out_valid=1. sum, cout and ovf are held stable until out_ready=1 at an edge, then go to IDLE.
//   in_ready=0 while DONE, so there is no overlap.
//   Throughput: one result per NCHUNK+2 cycles with out_ready tied high.
//   Handshake rules:
//     - Inputs are sampled only on the accepting edge; later changes to dataa/datab/cin/sub are ignored.
//     - in_valid while not IDLE is ignored; the producer must hold it.
//     - out_valid, once high, stays high until accepted.
//   Width rules: sum is WIDTH bits modulo 2^WIDTH; no saturation; ovf is a flag only.
//   Boundary conditions:
//     - Carry propagates across all chunks (0xFFFF+1 wraps to 0 with cout=1).
//     - rst_n low in any state aborts at once; no result is produced and the block restarts in IDLE.
//     - sum keeps its value after the DONE->IDLE exit until the next operation completes.
// CONFIGURATION
//   ADDER_SUB_EN defined:
//     - sub port present; sampled with the operands.
//     - sub=1: B'=~datab, carry-in forced to 1, cin ignored.
//     - sub=0: B'=datab, carry-in=cin.
//   ADDER_SUB_EN undefined:
//     - sub port absent; add only; B'=datab, carry-in=cin.
// TESTING (WIDTH=16, CHUNK=4 unless stated)
//   1. 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; out_valid exactly 4 cycles after accept.
//   2. 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. 0x1234+0x4321, cin=1 -> sum=0x5556, cout=0.
//   3. Hold out_ready=0 for 3 cycles in DONE -> sum/cout/ovf stable, in_ready=0.
//      A second in_valid is not accepted until after out_ready=1.
//   4. Drop rst_n at the 2nd RUN cycle -> out_valid=0, sum=0 at once.
//      After release: in_ready=1; the next op 0x0003+0x0004 gives 0x0007.
//   5. ADDER_SUB_EN: 0x0005-0x0007 -> 0xFFFE, cout=0, ovf=0.
//      0x8000-0x0001 -> 0x7FFF, cout=1, ovf=1.
//   6. WIDTH=16, CHUNK=16 -> 0xFFFF+0xFFFF gives 0xFFFE, cout=1; out_valid 1 cycle after accept.

Source files
------------

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: adds WIDTH-bit operands CHUNK bits per clock with a registered carry.
// Define ADDER_SUB_EN to add the sub port (A - B via ~B and forced carry-in).
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("chunked_serial_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             am_q, am_d, bm_q, bm_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic [WIDTH-1:0] b_ld;
  logic             c_ld;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] acc_nxt;

`ifdef ADDER_SUB_EN
  assign b_ld = sub ? ~datab : datab;
  assign c_ld = sub | cin;
`else
  assign b_ld = datab;
  assign c_ld = cin;
`endif

  assign csum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(c_q);
  // Chunks enter at the top and drift down, so chunk k lands at bit k*CHUNK after NCHUNK steps.
  assign acc_nxt = (acc_q >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    am_d    = am_q;
    bm_d    = bm_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = dataa;
          b_d     = b_ld;
          c_d     = c_ld;
          am_d    = dataa[WIDTH-1];
          bm_d    = b_ld[WIDTH-1];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        c_d   = csum[CHUNK];
        acc_d = acc_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Visible result only changes here, so sum holds across the next op's RUN phase.
          sum_d   = acc_nxt;
          cout_d  = csum[CHUNK];
          ovf_d   = (am_q == bm_q) && (acc_nxt[WIDTH-1] != am_q);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      am_q    <= am_d;
      bm_q    <= bm_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder: a 16/4 instance and a 16/16 instance.
module tb_chunked_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] dataa, datab, sum;
  logic        cin, cout, ovf;
  logic        sub;

  logic        v2, rdy2, ov2, or2;
  logic [15:0] a2, b2, s2;
  logic        ci2, co2, ovf2;
  logic        sub2;

  int nvec = 0;
  int nerr = 0;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dataa(dataa), .datab(datab), .cin(cin),
`ifdef ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
    .dataa(a2), .datab(b2), .cin(ci2),
`ifdef ADDER_SUB_EN
    .sub(sub2),
`endif
    .out_valid(ov2), .out_ready(or2),
    .sum(s2), .cout(co2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Present one operand set, let it be accepted, then scramble the inputs.
  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic ci, input string tag);
    dataa    = a;
    datab    = b;
    cin      = ci;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    dataa    = ~a;
    datab    = ~b;
    cin      = ~ci;
    chk($sformatf("%s_busy", tag), 32'(in_ready), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int elat, input logic [15:0] es,
                           input logic ec, input logic eo);
    int lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("%s_lat", tag), 32'(lat), 32'(elat));
    chk($sformatf("%s_sum", tag), 32'(sum), 32'(es));
    chk($sformatf("%s_cout", tag), 32'(cout), 32'(ec));
    chk($sformatf("%s_ovf", tag), 32'(ovf), 32'(eo));
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("%s_idle", tag), 32'(in_ready), 32'd1);
    chk($sformatf("%s_ovld", tag), 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dataa = '0; datab = '0; cin = 1'b0; sub = 1'b0;
    v2 = 1'b0; or2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0; sub2 = 1'b0;
    #2;
    chk("rst_inrdy", 32'(in_ready), 32'd1);
    chk("rst_ovld", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start(16'hFFFF, 16'h0001, 1'b0, "wrap");
    wait_done("wrap", 4, 16'h0000, 1'b1, 1'b0);
    take("wrap");

    start(16'h7FFF, 16'h0001, 1'b0, "ovf");
    wait_done("ovf", 4, 16'h8000, 1'b0, 1'b1);
    take("ovf");

    start(16'h1234, 16'h4321, 1'b1, "cin");
    chk("cin_keep", 32'(sum), 32'h8000);
    wait_done("cin", 4, 16'h5556, 1'b0, 1'b0);
    take("cin");

    // Stall in DONE with a second request pending.
    start(16'h00FF, 16'h0001, 1'b0, "hold");
    wait_done("hold", 4, 16'h0100, 1'b0, 1'b0);
    dataa = 16'h0010; datab = 16'h0020; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_sum", i), 32'(sum), 32'h0100);
      chk($sformatf("hold%0d_ovld", i), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_inrdy", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_exit_rdy", 32'(in_ready), 32'd1);
    chk("hold_exit_sum", 32'(sum), 32'h0100);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pend_busy", 32'(in_ready), 32'd0);
    wait_done("pend", 4, 16'h0030, 1'b0, 1'b0);
    take("pend");

    // Abort in the second RUN cycle.
    start(16'h1111, 16'h2222, 1'b0, "abort");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ovld", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_inrdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 32'(in_ready), 32'd1);
    start(16'h0003, 16'h0004, 1'b0, "post");
    wait_done("post", 4, 16'h0007, 1'b0, 1'b0);
    take("post");

`ifdef ADDER_SUB_EN
    sub = 1'b1;
    start(16'h0005, 16'h0007, 1'b0, "sub1");
    sub = 1'b0;
    wait_done("sub1", 4, 16'hFFFE, 1'b0, 1'b0);
    take("sub1");
    sub = 1'b1;
    start(16'h8000, 16'h0001, 1'b0, "sub2");
    sub = 1'b0;
    wait_done("sub2", 4, 16'h7FFF, 1'b1, 1'b1);
    take("sub2");
`endif

    // Single-chunk instance: one cycle per operation.
    chk("w16_rdy", 32'(rdy2), 32'd1);
    a2 = 16'hFFFF; b2 = 16'hFFFF; ci2 = 1'b0; v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0; a2 = '0; b2 = '0;
    begin
      int lat = 0;
      while (ov2 !== 1'b1 && lat < 64) begin
        @(negedge clk);
        lat++;
      end
      chk("w16_lat", 32'(lat), 32'd1);
    end
    chk("w16_sum", 32'(s2), 32'hFFFE);
    chk("w16_cout", 32'(co2), 32'd1);
    chk("w16_ovf", 32'(ovf2), 32'd0);
    or2 = 1'b1;
    @(negedge clk);
    or2 = 1'b0;
    chk("w16_idle", 32'(rdy2), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
